// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants, FSM encoding and duty check for the PWM ramp sequencer
package pwm_pkg;

  localparam logic [1:0] ADDR_CTRL     = 2'd0;
  localparam logic [1:0] ADDR_TARGET   = 2'd1;
  localparam logic [1:0] ADDR_INTERVAL = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam logic [1:0] PWM_DATA_ADDR = 2'd0;

  localparam logic [6:0] DUTY_STEP = 7'd10;
  localparam logic [6:0] DUTY_MAX  = 7'd100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    WRITE = 2'd2
  } seq_state_t;

  // The pwm slave only accepts 0, 10, ... 100.
  function automatic logic duty_valid(input logic [31:0] value);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i <= 32'(DUTY_MAX) / 32'(DUTY_STEP); i++) begin
      if (value == 32'(i) * 32'(DUTY_STEP)) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler emitting a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// rtl/pwm_ramp_sequencer.sv - walks the PWM duty toward a programmed target one step per interval
module pwm_ramp_sequencer
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest,
  output logic        busy
);

  logic        enable;
  logic [6:0]  target;
  logic [15:0] interval;
  logic        err;
  logic [6:0]  cur_duty;
  logic        at_target;
  logic [15:0] icnt, icnt_nx;
  logic [31:0] rd_mux;
  logic        tick;
  logic        launch, done;
  logic [6:0]  step_val;
  logic [15:0] eff_interval;
  seq_state_t  state, state_nx;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign m_address    = PWM_DATA_ADDR;
  assign eff_interval = (interval == 16'd0) ? 16'd1 : interval;
  assign step_val     = (target > cur_duty) ? cur_duty + DUTY_STEP : cur_duty - DUTY_STEP;

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:     rd_mux = {31'd0, enable};
      ADDR_TARGET:   rd_mux = {25'd0, target};
      ADDR_INTERVAL: rd_mux = {16'd0, interval};
      ADDR_STATUS:   rd_mux = {16'd0, 1'b0, cur_duty, 5'd0, err, at_target, busy};
      default:       rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      target    <= '0;
      interval  <= '0;
      err       <= 1'b0;
      readdata  <= '0;
      busy      <= 1'b0;
      at_target <= 1'b0;
    end else begin
      if (chipselect && write) begin
        case (address)
          ADDR_CTRL:     enable <= writedata[0];
          ADDR_TARGET: begin
            if (duty_valid(writedata)) target <= writedata[6:0];
            else                       err    <= 1'b1;
          end
          ADDR_INTERVAL: interval <= writedata[15:0];
          ADDR_STATUS:   err <= 1'b0;
          default: ;
        endcase
      end
      readdata  <= (chipselect && read) ? rd_mux : 32'd0;
      busy      <= enable && (cur_duty != target);
      at_target <= (cur_duty == target);
    end
  end

  // Direction is chosen at launch; an in-flight write always completes.
  always_comb begin
    state_nx = state;
    icnt_nx  = icnt;
    launch   = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (enable && cur_duty != target) begin
          state_nx = WAIT;
          icnt_nx  = '0;
        end
      end
      WAIT: begin
        if (!enable || cur_duty == target) begin
          state_nx = IDLE;
        end else if (tick) begin
          if (icnt + 16'd1 >= eff_interval) begin
            state_nx = WRITE;
            launch   = 1'b1;
          end else begin
            icnt_nx = icnt + 16'd1;
          end
        end
      end
      WRITE: begin
        if (!m_waitrequest) begin
          state_nx = IDLE;
          done     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      icnt         <= '0;
      cur_duty     <= '0;
      m_chipselect <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= '0;
    end else begin
      state <= state_nx;
      icnt  <= icnt_nx;
      if (launch) begin
        m_chipselect <= 1'b1;
        m_write      <= 1'b1;
        m_writedata  <= {25'd0, step_val};
      end else if (done) begin
        m_chipselect <= 1'b0;
        m_write      <= 1'b0;
        cur_duty     <= m_writedata[6:0];
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// tb/tb_pwm_ramp_sequencer.sv - self-checking bench for pwm_ramp_sequencer with a duty/timing reference model
module tb_pwm_ramp_sequencer;
  import pwm_pkg::*;

  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest = 1'b0;
  logic        busy;

  pwm_ramp_sequencer #(.TICK_DIV(TD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .address       (address),
    .chipselect    (chipselect),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .readdata      (readdata),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write       (m_write),
    .m_writedata   (m_writedata),
    .m_waitrequest (m_waitrequest),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A write completes at the edge where it was presented with waitrequest low.
  logic        last_w = 1'b0;
  logic [31:0] last_d = '0;
  int          wq_data[$];
  int          wq_cyc[$];
  always @(negedge clk) begin
    if (last_w && !m_waitrequest) begin
      wq_data.push_back(int'(last_d));
      wq_cyc.push_back(cyc);
    end
    last_w = m_write && m_chipselect;
    last_d = m_writedata;
  end

  int m_cur = 0, m_target = 0, m_interval = 0, m_err = 0, m_enable = 0;

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(m_cur) << 8;
    if (m_err != 0) s[2] = 1'b1;
    if (m_cur == m_target) s[1] = 1'b1;
    if (m_enable != 0 && m_cur != m_target) s[0] = 1'b1;
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic avs_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
    step();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic avs_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; read = 1'b1;
    step();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic do_ramp(input int t, input string tag);
    int eq[$];
    int v;
    int eff;
    logic [31:0] rd;
    v   = m_cur;
    eff = (m_interval == 0) ? 1 : m_interval;
    if (m_enable != 0) begin
      while (v != t) begin
        v = (t > v) ? v + 10 : v - 10;
        eq.push_back(v);
      end
    end
    wq_data.delete();
    wq_cyc.delete();
    avs_write(ADDR_TARGET, 32'(t));
    m_target = t;
    for (int k = 0; k < eq.size() * (eff + 2) * TD + 40 && wq_data.size() < eq.size(); k++) step();
    repeat (3 * TD * (eff + 1)) step();
    check({tag, "_nwrites"}, 32'(wq_data.size()), 32'(eq.size()));
    for (int i = 0; i < eq.size() && i < wq_data.size(); i++) begin
      check({tag, "_data"}, 32'(wq_data[i]), 32'(eq[i]));
      if (i > 0) check({tag, "_spacing"}, 32'(wq_cyc[i] - wq_cyc[i-1]), 32'(eff * TD));
    end
    if (m_enable != 0) m_cur = t;
    avs_read(ADDR_STATUS, rd);
    check({tag, "_status"}, rd, exp_status());
  endtask

  initial begin
    logic [31:0] rd;
    int t0;
    int k;
    int bad;

    repeat (3) step();
    reset_n = 1'b1;
    #1;
    check("rst_readdata", readdata, 32'd0);
    check("rst_m_write", {31'd0, m_write}, 32'd0);
    check("rst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("rst_m_wdata", m_writedata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_addr", {30'd0, m_address}, 32'd0);
    step();
    avs_read(ADDR_STATUS, rd);
    check("rst_status", rd, exp_status());

    // Basic up and down ramps
    avs_write(ADDR_INTERVAL, 32'd2); m_interval = 2;
    avs_write(ADDR_CTRL, 32'd1);     m_enable = 1;
    do_ramp(30, "up30");
    do_ramp(0, "down0");

    // Illegal targets are dropped and flag err
    wq_data.delete();
    avs_write(ADDR_TARGET, 32'd35);
    avs_write(ADDR_TARGET, 32'd120);
    m_err = 1;
    repeat (20) step();
    check("bad_nwrites", 32'(wq_data.size()), 32'd0);
    avs_read(ADDR_TARGET, rd);
    check("bad_target_kept", rd, 32'(m_target));
    avs_read(ADDR_STATUS, rd);
    check("bad_err_set", rd, exp_status());
    avs_write(ADDR_STATUS, 32'd0); m_err = 0;
    avs_read(ADDR_STATUS, rd);
    check("err_cleared", rd, exp_status());

    for (int it = 0; it < 6; it++) begin
      m_interval = $urandom_range(0, 3);
      avs_write(ADDR_INTERVAL, 32'(m_interval));
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) bad = 101 + $urandom_range(0, 26);
        else bad = 10 * $urandom_range(0, 9) + $urandom_range(1, 9);
        avs_write(ADDR_TARGET, 32'(bad));
        m_err = 1;
      end
      if ($urandom_range(0, 3) == 0) begin
        avs_write(ADDR_STATUS, 32'd0);
        m_err = 0;
      end
      do_ramp(10 * $urandom_range(0, 10), "rand");
      avs_read(ADDR_TARGET, rd);
      check("rand_target_rb", rd, 32'(m_target));
    end

    // Reversal during the write of 20
    avs_write(ADDR_INTERVAL, 32'd1); m_interval = 1;
    do_ramp(0, "home");
    wq_data.delete();
    wq_cyc.delete();
    avs_write(ADDR_TARGET, 32'd60); m_target = 60;
    k = 0;
    while (!(m_write && m_writedata == 32'd20) && k < 200) begin step(); k++; end
    avs_write(ADDR_TARGET, 32'd0); m_target = 0;
    repeat (80) step();
    check("rev_nwrites", 32'(wq_data.size()), 32'd4);
    if (wq_data.size() == 4) begin
      check("rev_w0", 32'(wq_data[0]), 32'd10);
      check("rev_w1", 32'(wq_data[1]), 32'd20);
      check("rev_w2", 32'(wq_data[2]), 32'd10);
      check("rev_w3", 32'(wq_data[3]), 32'd0);
    end
    m_cur = 0;
    avs_read(ADDR_STATUS, rd);
    check("rev_status", rd, exp_status());

    // Stalled first write toward 100
    wq_data.delete();
    wq_cyc.delete();
    m_waitrequest = 1'b1;
    avs_write(ADDR_TARGET, 32'd100); m_target = 100;
    k = 0;
    while (!m_write && k < 60) begin step(); k++; end
    check("stall_seen", {31'd0, m_write}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_wdata", m_writedata, 32'd10);
      check("stall_wr", {30'd0, m_chipselect, m_write}, 32'd3);
    end
    avs_read(ADDR_STATUS, rd);
    check("stall_cur", {24'd0, rd[15:8]}, 32'd0);
    check("stall_busy", {31'd0, rd[0]}, 32'd1);
    check("stall_wdata6", m_writedata, 32'd10);
    m_waitrequest = 1'b0;
    step();
    check("release_wr_low", {31'd0, m_write}, 32'd0);
    check("release_nwrites", 32'(wq_data.size()), 32'd1);
    t0 = (wq_cyc.size() > 0) ? wq_cyc[0] : 0;
    m_cur = 10;
    avs_read(ADDR_STATUS, rd);
    check("release_cur", {24'd0, rd[15:8]}, 32'd10);

    // Disable while the 40 write is on the bus
    k = 0;
    while (!(m_write && m_writedata == 32'd40) && k < 200) begin step(); k++; end
    avs_write(ADDR_CTRL, 32'd0); m_enable = 0;
    repeat (60) step();
    check("dis_nwrites", 32'(wq_data.size()), 32'd4);
    if (wq_data.size() == 4) begin
      check("dis_last", 32'(wq_data[3]), 32'd40);
      check("after_stall_gap_ok",
            {31'd0, (wq_cyc[1] - t0 >= 3) && (wq_cyc[1] - t0 <= 2 + TD)}, 32'd1);
      check("dis_spacing", 32'(wq_cyc[2] - wq_cyc[1]), 32'(TD));
    end
    m_cur = 40;
    avs_read(ADDR_STATUS, rd);
    check("dis_status", rd, exp_status());

    // Reset in the middle of a WAIT at 50
    avs_write(ADDR_INTERVAL, 32'd3); m_interval = 3;
    avs_write(ADDR_TARGET, 32'd50);  m_target = 50;
    avs_write(ADDR_CTRL, 32'd1);     m_enable = 1;
    do_ramp(50, "to50");
    wq_data.delete();
    wq_cyc.delete();
    avs_write(ADDR_TARGET, 32'd100); m_target = 100;
    repeat (6) step();
    check("wait_no_write", {31'd0, m_write}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_m_write", {31'd0, m_write}, 32'd0);
    check("arst_m_cs", {31'd0, m_chipselect}, 32'd0);
    check("arst_m_wdata", m_writedata, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_readdata", readdata, 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    m_cur = 0; m_target = 0; m_interval = 0; m_err = 0; m_enable = 0;
    repeat (2) step();
    avs_read(ADDR_STATUS, rd);
    check("arst_status", rd, exp_status());
    avs_read(ADDR_CTRL, rd);
    check("arst_ctrl", rd, 32'd0);
    avs_read(ADDR_TARGET, rd);
    check("arst_target", rd, 32'd0);
    repeat (30) step();
    check("arst_nwrites", 32'(wq_data.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
